// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin arbiter sharing one flash SPI read handler between requesters
module flash_read_arbiter #(
  parameter int          g_num_req        = 2,
  parameter logic [23:0] g_timeout_cycles = 24'd2000000
) (
  input  logic                      i_sys_clk,
  input  logic                      i_reset,
  input  logic                      i_spi_bus_free,
  input  logic [g_num_req-1:0]      i_req,
  input  logic [24*g_num_req-1:0]   i_addr,
  input  logic [12*g_num_req-1:0]   i_num,
  output logic [g_num_req-1:0]      o_grant,
  output logic [g_num_req-1:0]      o_ready,
  output logic [g_num_req-1:0]      o_error,
  output logic                      o_data_request,
  output logic [23:0]               o_read_addr,
  output logic [11:0]               o_read_num,
  input  logic                      i_data_ready,
  input  logic                      i_command_error
);
  localparam int IW = g_num_req > 1 ? $clog2(g_num_req) : 1;
  localparam logic [23:0] TMO = g_timeout_cycles - 24'd1;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DRAIN} state_t;
  state_t               state_q, state_d;
  logic [g_num_req-1:0] grant_q, grant_d, ready_q, ready_d, error_q, error_d;
  logic                 dreq_q, dreq_d;
  logic [23:0]          addr_q, addr_d, cnt_q, cnt_d;
  logic [11:0]          num_q, num_d;
  logic [IW-1:0]        last_q, last_d, cur_q, cur_d, sel;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % g_num_req);
  endfunction
  assign o_grant        = grant_q;
  assign o_ready        = ready_q;
  assign o_error        = error_q;
  assign o_data_request = dreq_q;
  assign o_read_addr    = addr_q;
  assign o_read_num     = num_q;
  // first pending requester after the last owner; scanning downward lets the nearest one win
  always_comb begin
    sel = last_q;
    for (int i = g_num_req; i >= 1; i--)
      if (i_req[wrap(int'(last_q) + i)]) sel = wrap(int'(last_q) + i);
  end
  // next-state and registered outputs of the grant/issue/hold/drain sequence
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ready_d = ready_q;
    error_d = error_q;
    dreq_d  = dreq_q;
    addr_d  = addr_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: if (i_spi_bus_free && |i_req) begin
        grant_d      = '0;
        grant_d[sel] = 1'b1;
        addr_d       = i_addr[24*sel +: 24];
        num_d        = i_num[12*sel +: 12];
        dreq_d       = 1'b1;
        cnt_d        = '0;
        cur_d        = sel;
        state_d      = ISSUE;
      end
      ISSUE: begin
        cnt_d = cnt_q == TMO ? cnt_q : cnt_q + 24'd1;
        if (i_data_ready) begin
          ready_d[cur_q] = 1'b1;
          error_d[cur_q] = i_command_error;
          state_d        = HOLD;
        end else if (cnt_q == TMO) begin
          dreq_d         = 1'b0;
          ready_d[cur_q] = 1'b1;
          error_d[cur_q] = 1'b1;
          state_d        = HOLD;
        end
      end
      HOLD: if (!i_req[cur_q]) begin
        ready_d = '0;
        error_d = '0;
        dreq_d  = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: if (!i_data_ready) begin
        grant_d = '0;
        last_d  = cur_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset leaves requester 0 with first priority
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ready_q <= '0;
      error_q <= '0;
      dreq_q  <= 1'b0;
      addr_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(g_num_req - 1);
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      error_q <= error_d;
      dreq_q  <= dreq_d;
      addr_q  <= addr_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
    end
  end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: directed and randomized transactions against a round-robin reference
module tb_flash_read_arbiter;
  localparam int N = 2;
  localparam int T = 10;
  logic          i_sys_clk = 0, i_reset = 1, i_spi_bus_free = 1;
  logic [N-1:0]  i_req = '0;
  logic [24*N-1:0] i_addr = '0;
  logic [12*N-1:0] i_num = '0;
  logic [N-1:0]  o_grant, o_ready, o_error;
  logic          o_data_request, i_data_ready = 0, i_command_error = 0;
  logic [23:0]   o_read_addr;
  logic [11:0]   o_read_num;
  logic [23:0]   a [N];
  logic [11:0]   n [N];
  int checks = 0, passes = 0, last = N - 1;
  flash_read_arbiter #(.g_num_req(N), .g_timeout_cycles(24'(T))) dut (
    .i_sys_clk(i_sys_clk), .i_reset(i_reset), .i_spi_bus_free(i_spi_bus_free),
    .i_req(i_req), .i_addr(i_addr), .i_num(i_num), .o_grant(o_grant),
    .o_ready(o_ready), .o_error(o_error), .o_data_request(o_data_request),
    .o_read_addr(o_read_addr), .o_read_num(o_read_num),
    .i_data_ready(i_data_ready), .i_command_error(i_command_error));
  always #5 i_sys_clk = ~i_sys_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic put();
    for (int j = 0; j < N; j++) begin
      i_addr[24*j +: 24] = a[j];
      i_num[12*j +: 12]  = n[j];
    end
  endtask
  function automatic int pick();
    for (int k = 1; k <= N; k++)
      if (i_req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic do_reset();
    i_reset = 1; i_req = '0; i_data_ready = 0; i_command_error = 0;
    @(negedge i_sys_clk);
    chk("rst_grant", o_grant, 0); chk("rst_ready", o_ready, 0); chk("rst_error", o_error, 0);
    chk("rst_dreq", o_data_request, 0); chk("rst_addr", o_read_addr, 0); chk("rst_num", o_read_num, 0);
    i_reset = 0; last = N - 1;
  endtask
  task automatic serve(input int lat, input bit cerr, input bit tmo, input bit early,
                       input int hold, input int d, input bit poke, output int g);
    logic [23:0] ea;
    logic [11:0] en;
    g = pick();
    if (g < 0) begin chk("no_request", 0, 1); return; end
    ea = a[g]; en = n[g];
    @(negedge i_sys_clk);
    chk("grant", o_grant, 1 << g); chk("dreq_up", o_data_request, 1);
    chk("read_addr", o_read_addr, ea); chk("read_num", o_read_num, en);
    a[g] = 24'($urandom); n[g] = 12'($urandom); put();
    for (int j = 0; j < N; j++)
      if (poke && j != g && !i_req[j] && $urandom_range(1)) begin
        a[j] = 24'($urandom); n[j] = 12'($urandom); put(); i_req[j] = 1;
      end
    if (early) i_req[g] = 0;
    if (!tmo) begin
      repeat (lat) begin @(negedge i_sys_clk); chk("wait_ready", o_ready, 0); end
      i_data_ready = 1; i_command_error = cerr;
      @(negedge i_sys_clk);
      chk("ready", o_ready, 1 << g); chk("error", o_error, 32'(cerr) << g);
      chk("dreq_hold", o_data_request, 1);
      i_command_error = 1'($urandom);
    end else begin
      repeat (T - 1) begin
        @(negedge i_sys_clk); chk("tmo_wait", o_ready, 0); chk("tmo_dreq", o_data_request, 1);
      end
      @(negedge i_sys_clk);
      chk("tmo_ready", o_ready, 1 << g); chk("tmo_error", o_error, 1 << g);
      chk("tmo_dreq_drop", o_data_request, 0);
    end
    if (!early) begin
      repeat (hold) begin
        @(negedge i_sys_clk); chk("held_ready", o_ready, 1 << g);
        chk("held_error", o_error, (tmo ? 1 : 32'(cerr)) << g);
      end
      i_req[g] = 0;
    end
    @(negedge i_sys_clk);
    chk("rel_ready", o_ready, 0); chk("rel_error", o_error, 0);
    chk("rel_dreq", o_data_request, 0); chk("drain_grant", o_grant, 1 << g);
    chk("stable_addr", o_read_addr, ea); chk("stable_num", o_read_num, en);
    repeat (d) begin @(negedge i_sys_clk); chk("drain_hold", o_grant, 1 << g); end
    i_data_ready = 0;
    @(negedge i_sys_clk);
    chk("idle_grant", o_grant, 0);
    last = g;
  endtask
  initial begin
    int g;
    for (int j = 0; j < N; j++) begin a[j] = '0; n[j] = '0; end
    @(negedge i_sys_clk);
    do_reset();
    a[0] = 24'h5; n[0] = 12'd16; put(); i_req = 2'b01;
    serve(3, 0, 0, 0, 1, 1, 0, g);
    chk("single_owner", g, 0);
    do_reset();
    a[0] = 24'h0; n[0] = 12'd24; a[1] = 24'h1FFFC; n[1] = 12'd16; put(); i_req = 2'b11;
    serve(4, 0, 0, 0, 2, 0, 0, g); chk("both_first", g, 0);
    serve(2, 0, 0, 0, 0, 2, 0, g); chk("both_second", g, 1);
    do_reset();
    i_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      serve(t + 1, 0, 0, 0, 1, 0, 0, g);
      chk("rotation", g, t % 2);
      i_req[g] = 1;
    end
    do_reset();
    i_spi_bus_free = 0; i_req = 2'b01;
    repeat (20) begin @(negedge i_sys_clk); chk("bus_busy", o_data_request, 0); end
    i_spi_bus_free = 1;
    serve(5, 0, 0, 0, 1, 1, 0, g);
    i_req = 2'b01;
    serve(0, 0, 1, 0, 2, 0, 0, g);
    i_req = 2'b10;
    serve(9, 0, 0, 0, 1, 1, 0, g);
    i_req = 2'b01;
    serve(6, 1, 0, 0, 1, 1, 0, g);
    i_req = 2'b10;
    serve(3, 0, 0, 1, 0, 1, 0, g);
    i_req = 2'b01;
    @(negedge i_sys_clk);
    chk("pre_reset_grant", o_grant, 1);
    do_reset();
    a[1] = 24'hABCDE; n[1] = 12'd7; put(); i_req = 2'b10;
    serve(2, 0, 0, 0, 1, 1, 0, g);
    chk("after_reset_owner", g, 1);
    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < N; j++)
        if (!i_req[j] && $urandom_range(1)) begin
          a[j] = 24'($urandom); n[j] = 12'($urandom); put(); i_req[j] = 1;
        end
      if (i_req == 0) i_req[$urandom_range(N - 1)] = 1;
      if ($urandom_range(3) == 0) begin
        i_spi_bus_free = 0;
        repeat ($urandom_range(1, 4)) begin @(negedge i_sys_clk); chk("rnd_bus_busy", o_data_request, 0); end
        i_spi_bus_free = 1;
      end
      begin
        bit tmo;
        tmo = $urandom_range(4) == 0;
        serve($urandom_range(9), 1'($urandom), tmo, $urandom_range(3) == 0,
              $urandom_range(2), tmo ? 0 : $urandom_range(2), 1, g);
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
